// File: rtl/layer_fetch_pkg.sv
// -----------------------------------------------------------------------------
// layer_fetch_pkg
// Shared types and constants for the layer fetch arbiter and its compositor.
//   state_t    : fetch controller states (IDLE, FETCH)
//   LF_ADDR_W  : default SRAM address width
//   LF_DATA_W  : default pixel width (4:4:4 RGB)
//   LF_KEY     : default chroma-key colour for sprite layers
//   LF_BLACK   : pixel driven when blanked or when no layer contributes
// -----------------------------------------------------------------------------
package layer_fetch_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  localparam int          LF_ADDR_W = 17;
  localparam int          LF_DATA_W = 12;
  localparam logic [11:0] LF_KEY    = 12'h0f0;
  localparam logic [11:0] LF_BLACK  = 12'h000;

endpackage

// File: rtl/layer_priority_mux.sv
// -----------------------------------------------------------------------------
// layer_priority_mux
// Combinational compositor: picks the topmost requested, non-transparent layer.
// The background (highest index) is never keyed. Blanking forces black.
// Ports:
//   i_cap      in  N_LAYERS*DATA_W  captured pixels, layer i at [i*DATA_W +: DATA_W]
//   i_req      in  N_LAYERS         per-layer request bits of the window
//   i_video_on in  1                visible-area flag of the window
//   o_pixel    out DATA_W           composited pixel
// -----------------------------------------------------------------------------
module layer_priority_mux
  import layer_fetch_pkg::*;
#(
  parameter int                N_LAYERS = 4,
  parameter int                DATA_W   = LF_DATA_W,
  parameter logic [DATA_W-1:0] KEY      = DATA_W'(LF_KEY)
) (
  input  logic [N_LAYERS*DATA_W-1:0] i_cap,
  input  logic [N_LAYERS-1:0]        i_req,
  input  logic                       i_video_on,
  output logic [DATA_W-1:0]          o_pixel
);

  logic w_found;

  always_comb begin
    o_pixel = DATA_W'(LF_BLACK);
    w_found = 1'b0;
    for (int i = 0; i < N_LAYERS - 1; i++) begin
      if (!w_found && i_req[i] && (i_cap[i*DATA_W +: DATA_W] != KEY)) begin
        o_pixel = i_cap[i*DATA_W +: DATA_W];
        w_found = 1'b1;
      end
    end
    if (!w_found && i_req[N_LAYERS-1]) begin
      o_pixel = i_cap[(N_LAYERS-1)*DATA_W +: DATA_W];
    end
    if (!i_video_on) begin
      o_pixel = DATA_W'(LF_BLACK);
    end
  end

endmodule

// File: rtl/layer_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// layer_fetch_arbiter
// Time-multiplexes one read-only SRAM port over N display layers and composites
// the fetched pixels. A pixel_tick snapshots all layer requests/addresses; each
// layer then gets one fixed read slot, and the composited pixel is presented
// with a one-cycle rgb_valid pulse N_LAYERS+2 cycles after the tick.
// Ports:
//   clk, reset_n  in   clock, synchronous active-low reset
//   pixel_tick    in   starts a fetch window (accepted in IDLE or on last slot)
//   video_on      in   visible-area flag, snapshotted with pixel_tick
//   layer_req     in   per-layer request
//   layer_addr    in   packed per-layer SRAM addresses
//   sram_en/addr  out  SRAM read strobe and address
//   sram_data     in   SRAM read data, one cycle after sram_en
//   rgb_out       out  composited pixel, held between valid pulses
//   rgb_valid     out  one-cycle pulse when rgb_out updates
//   overrun       out  sticky: tick arrived while a window was still issuing
// -----------------------------------------------------------------------------
module layer_fetch_arbiter
  import layer_fetch_pkg::*;
#(
  parameter int                N_LAYERS = 4,
  parameter int                ADDR_W   = LF_ADDR_W,
  parameter int                DATA_W   = LF_DATA_W,
  parameter logic [DATA_W-1:0] KEY      = DATA_W'(LF_KEY)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       pixel_tick,
  input  logic                       video_on,
  input  logic [N_LAYERS-1:0]        layer_req,
  input  logic [N_LAYERS*ADDR_W-1:0] layer_addr,
  output logic                       sram_en,
  output logic [ADDR_W-1:0]          sram_addr,
  input  logic [DATA_W-1:0]          sram_data,
  output logic [DATA_W-1:0]          rgb_out,
  output logic                       rgb_valid,
  output logic                       overrun
);

  localparam int                SLOT_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam logic [SLOT_W-1:0] LAST   = SLOT_W'(N_LAYERS - 1);

  state_t              r_state, w_state_nxt;
  logic [SLOT_W-1:0]   r_slot, w_slot_nxt;
  logic                w_accept, w_issue, w_ovr_set;

  logic [N_LAYERS-1:0] r_snap_req;
  logic [ADDR_W-1:0]   r_snap_addr [N_LAYERS];
  logic                r_snap_vid;

  logic                r_vld_p1;
  logic [SLOT_W-1:0]   r_slot_p1;
  logic                r_req_p1;
  logic                r_vid_p1;

  logic [DATA_W-1:0]   r_cap [N_LAYERS];
  logic [N_LAYERS-1:0] r_cap_req;

  logic [N_LAYERS*DATA_W-1:0] w_cap_cmp;
  logic [N_LAYERS-1:0]        w_req_cmp;
  logic [DATA_W-1:0]          w_pixel;
  logic                       w_compose;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  // The last slot doubles as an accept point so windows can run back to back.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (pixel_tick) begin
          w_accept    = 1'b1;
          w_state_nxt = FETCH;
          w_slot_nxt  = '0;
        end
      end
      FETCH: begin
        w_issue = 1'b1;
        if (r_slot == LAST) begin
          w_slot_nxt = '0;
          if (pixel_tick) begin
            w_accept    = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_slot_nxt = r_slot + SLOT_W'(1);
          w_ovr_set  = pixel_tick;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_slot_nxt  = '0;
      end
    endcase
  end

  // Unrequested layers keep their slot but leave the SRAM idle.
  always_comb begin
    sram_en   = 1'b0;
    sram_addr = '0;
    if (w_issue) begin
      sram_en   = r_snap_req[r_slot];
      sram_addr = r_snap_addr[r_slot];
    end
  end

  // ---- snapshot / issue stage ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_snap_req <= '0;
      r_snap_vid <= 1'b0;
      for (int i = 0; i < N_LAYERS; i++) r_snap_addr[i] <= '0;
      r_vld_p1   <= 1'b0;
      r_slot_p1  <= '0;
      r_req_p1   <= 1'b0;
      r_vid_p1   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_snap_req <= layer_req;
        r_snap_vid <= video_on;
        for (int i = 0; i < N_LAYERS; i++) r_snap_addr[i] <= layer_addr[i*ADDR_W +: ADDR_W];
      end
      r_vld_p1  <= w_issue;
      r_slot_p1 <= r_slot;
      r_req_p1  <= w_issue & r_snap_req[r_slot];
      r_vid_p1  <= r_snap_vid;
      if (w_ovr_set) overrun <= 1'b1;
    end
  end

  // ---- capture stage ----
  // The last slot's data is bypassed straight into the compositor so the
  // pixel registers in the same cycle that capture lands. Request and video
  // flags travel with the slot, since the snapshot may already belong to the
  // next window by then.
  always_comb begin
    w_cap_cmp = '0;
    w_req_cmp = r_cap_req;
    for (int i = 0; i < N_LAYERS; i++) begin
      w_cap_cmp[i*DATA_W +: DATA_W] = r_cap[i];
      if (r_vld_p1 && (r_slot_p1 == SLOT_W'(i))) begin
        w_req_cmp[i] = r_req_p1;
        if (r_req_p1) w_cap_cmp[i*DATA_W +: DATA_W] = sram_data;
      end
    end
  end

  assign w_compose = r_vld_p1 && (r_slot_p1 == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_LAYERS; i++) r_cap[i] <= '0;
      r_cap_req <= '0;
    end else if (r_vld_p1) begin
      r_cap_req[r_slot_p1] <= r_req_p1;
      if (r_req_p1) r_cap[r_slot_p1] <= sram_data;
    end
  end

  layer_priority_mux #(
    .N_LAYERS (N_LAYERS),
    .DATA_W   (DATA_W),
    .KEY      (KEY)
  ) u_mux (
    .i_cap      (w_cap_cmp),
    .i_req      (w_req_cmp),
    .i_video_on (r_vid_p1),
    .o_pixel    (w_pixel)
  );

  // ---- compose / output stage ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rgb_out   <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= w_compose;
      if (w_compose) rgb_out <= w_pixel;
    end
  end

endmodule

// File: tb/tb_layer_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_layer_fetch_arbiter
// Scoreboard bench for layer_fetch_arbiter: a behavioural SRAM, a reference
// compositor evaluated at tick time, and a monitor that pops expectations
// (pixel and arrival cycle) on every rgb_valid. Also probes the compositor
// sub-module directly.
// -----------------------------------------------------------------------------
module tb_layer_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pixel_tick;
  logic        video_on;
  logic [3:0]  layer_req;
  logic [67:0] layer_addr;
  logic        sram_en;
  logic [16:0] sram_addr;
  logic [11:0] sram_data;
  logic [11:0] rgb_out;
  logic        rgb_valid;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_cnt = 0;
  int last_en_cyc = -1;
  int vcnt = 0;

  typedef struct {
    logic [11:0] pix;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [11:0] mem [int];

  always #5 clk = ~clk;

  layer_fetch_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pixel_tick (pixel_tick),
    .video_on   (video_on),
    .layer_req  (layer_req),
    .layer_addr (layer_addr),
    .sram_en    (sram_en),
    .sram_addr  (sram_addr),
    .sram_data  (sram_data),
    .rgb_out    (rgb_out),
    .rgb_valid  (rgb_valid),
    .overrun    (overrun)
  );

  logic [47:0] m_cap;
  logic [3:0]  m_req;
  logic        m_vid;
  logic [11:0] m_pix;

  layer_priority_mux u_mux_ut (
    .i_cap      (m_cap),
    .i_req      (m_req),
    .i_video_on (m_vid),
    .o_pixel    (m_pix)
  );

  function automatic logic [11:0] rd(input logic [16:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 12'h000;
  endfunction

  function automatic logic [11:0] ref_pix(input logic [3:0] req, input logic vid,
                                          input logic [67:0] a);
    if (!vid) return 12'h000;
    for (int i = 0; i < 3; i++)
      if (req[i] && rd(a[i*17 +: 17]) != 12'h0f0) return rd(a[i*17 +: 17]);
    if (req[3]) return rd(a[51 +: 17]);
    return 12'h000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sram_en) sram_data <= rd(sram_addr);
  end

  always @(negedge clk) begin
    if (sram_en) begin
      en_cnt++;
      last_en_cyc = cyc;
    end
    if (rgb_valid) begin
      vcnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rgb_out", 32'(rgb_out), 32'(e.pix));
        chk("rgb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Call at #1 after a posedge; the tick is sampled on the next edge.
  task automatic tick(input logic [3:0] req, input logic vid, input logic [67:0] addr,
                      input bit push);
    layer_req  = req;
    video_on   = vid;
    layer_addr = addr;
    pixel_tick = 1'b1;
    if (push) exp_q.push_back('{ref_pix(req, vid, addr), cyc + 6});
    @(posedge clk); #1;
    pixel_tick = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    cycles(2);
  endtask

  function automatic logic [67:0] pack_addr(input int a0, input int a1, input int a2, input int a3);
    return {17'(a3), 17'(a2), 17'(a1), 17'(a0)};
  endfunction

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, wanted finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int v0;
    reset_n    = 1'b0;
    pixel_tick = 1'b0;
    video_on   = 1'b0;
    layer_req  = '0;
    layer_addr = '0;

    // compositor sub-module unit checks
    m_cap = {12'h111, 12'hff0, 12'h00f, 12'h0f0}; m_req = 4'b0000; m_vid = 1'b1; #1;
    chk("mux_none", 32'(m_pix), 32'h000);
    m_req = 4'b1111; #1;
    chk("mux_skip_key", 32'(m_pix), 32'h00f);
    m_cap = {12'h0f0, 36'h0}; m_req = 4'b1000; #1;
    chk("mux_bg_not_keyed", 32'(m_pix), 32'h0f0);
    m_vid = 1'b0; #1;
    chk("mux_blank", 32'(m_pix), 32'h000);

    // reset state
    cycles(3);
    @(negedge clk);
    chk("rst_sram_en", 32'(sram_en), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_rgb_out", 32'(rgb_out), 32'h000);
    chk("rst_rgb_valid", 32'(rgb_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cycles(2);

    // background only
    mem[5] = 12'h555; mem[6] = 12'h666; mem[7] = 12'h777; mem[100] = 12'h123;
    en_cnt = 0;
    t0 = cyc;
    tick(4'b1000, 1'b1, pack_addr(5, 6, 7, 100), 1'b1);
    drain("bg_drain");
    chk("bg_en_count", 32'(en_cnt), 32'd1);
    chk("bg_en_cycle", 32'(last_en_cyc), 32'(t0 + 4));
    chk("bg_rgb_hold", 32'(rgb_out), 32'h123);

    // transparency
    mem[200] = 12'h0f0; mem[300] = 12'habc;
    tick(4'b1001, 1'b1, pack_addr(200, 5, 6, 300), 1'b1);
    drain("key_drain");
    mem[200] = 12'hf00;
    tick(4'b1001, 1'b1, pack_addr(200, 5, 6, 300), 1'b1);
    drain("opaque_drain");

    // priority
    mem[400] = 12'h0f0; mem[401] = 12'h00f; mem[402] = 12'hff0; mem[403] = 12'h111;
    tick(4'b1111, 1'b1, pack_addr(400, 401, 402, 403), 1'b1);
    drain("prio_drain");

    // back-to-back windows, alternating blanking, addresses scrambled after tick
    mem[500] = 12'h0f0; mem[501] = 12'h321; mem[502] = 12'h654; mem[503] = 12'h987;
    v0 = vcnt;
    for (int w = 0; w < 8; w++) begin
      tick({1'b1, 3'(w * 3 + 1)}, (w % 2) == 0, pack_addr(500, 501, 502, 503), 1'b1);
      for (int k = 0; k < 3; k++) begin
        layer_addr = {$urandom, $urandom, $urandom};
        layer_req  = 4'($urandom);
        video_on   = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    drain("b2b_drain");
    chk("b2b_valid_count", 32'(vcnt - v0), 32'd8);
    chk("b2b_overrun", 32'(overrun), 32'd0);

    // overrun
    v0 = vcnt;
    t0 = cyc;
    tick(4'b1000, 1'b1, pack_addr(5, 6, 7, 100), 1'b1);
    cycles(1);
    pixel_tick = 1'b1;
    @(negedge clk);
    chk("ovr_not_yet", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    pixel_tick = 1'b0;
    @(negedge clk);
    chk("ovr_set_cycle", 32'(cyc), 32'(t0 + 3));
    chk("ovr_set", 32'(overrun), 32'd1);
    drain("ovr_drain");
    chk("ovr_valid_count", 32'(vcnt - v0), 32'd1);
    cycles(100);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // reset mid-window
    v0 = vcnt;
    tick(4'b1111, 1'b1, pack_addr(400, 401, 402, 403), 1'b0);
    cycles(2);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_sram_en", 32'(sram_en), 32'd0);
    chk("mid_rst_rgb_out", 32'(rgb_out), 32'h000);
    chk("mid_rst_rgb_valid", 32'(rgb_valid), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    cycles(10);
    chk("mid_rst_no_valid", 32'(vcnt - v0), 32'd0);
    tick(4'b1111, 1'b1, pack_addr(400, 401, 402, 403), 1'b1);
    drain("post_rst_drain");
    chk("post_rst_valid_count", 32'(vcnt - v0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_fetch_arbiter.md
# layer_fetch_arbiter

Shares one single-port, read-only frame/sprite SRAM among N display layers (background plus sprite layers) and composites the fetched pixels. It sits between the per-layer address generation units and the VGA RGB register. On each `pixel_tick` it snapshots every layer's request and address, then issues one SRAM read per active layer in fixed slots. It then selects the topmost non-transparent pixel and presents it with a one-cycle valid pulse.

## Interface
Parameters:
- `N_LAYERS`, 4: number of layers; layer 0 is topmost, layer N_LAYERS-1 is background.
- `ADDR_W`, 17: SRAM address width.
- `DATA_W`, 12: pixel width (4:4:4 RGB).
- `KEY`, 12'h0f0: chroma-key (transparent) colour for sprite layers.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  reset, synchronous, active-low
- `pixel_tick`  in  1  one-cycle pulse starting a fetch window
- `video_on`  in  1  visible-area flag, sampled with `pixel_tick`
- `layer_req`  in  N_LAYERS  per-layer "pixel inside region" request
- `layer_addr`  in  N_LAYERS*ADDR_W  packed per-layer SRAM addresses; layer i occupies bits [i*ADDR_W +: ADDR_W]
- `sram_en`  out  1  SRAM read enable
- `sram_addr`  out  ADDR_W  SRAM read address
- `sram_data`  in  DATA_W  SRAM read data, valid 1 cycle after `sram_en`
- `rgb_out`  out  DATA_W  composited pixel
- `rgb_valid`  out  1  one-cycle pulse when `rgb_out` is updated
- `overrun`  out  1  sticky flag: a `pixel_tick` arrived while FETCH was still issuing

## Operation
- State machine with states IDLE and FETCH, plus slot counter `slot` (clog2(N_LAYERS) bits).
- In IDLE, `pixel_tick` snapshots `layer_req`, `layer_addr` and `video_on` into internal registers. The block then enters FETCH with `slot`=0.
- In FETCH, each cycle drives `sram_addr`=snap_addr[slot] and `sram_en`=snap_req[slot]. Layers that are not requested do not assert `sram_en`, but they still consume their slot.
  - After slot N_LAYERS-1 the block returns to IDLE.
  - In the same cycle as that return, a `pixel_tick` is accepted and starts the next window back to back.
- Capture: one cycle after each slot, `sram_data` is written to cap[slot_d], where slot_d is the delayed slot index. A capture is skipped if that slot's request was 0.
- Compose: evaluated in the cycle the last capture lands, and registered into `rgb_out`. The rules are:
  - The first layer i (lowest index) with req=1 and cap≠KEY wins, for i < N_LAYERS-1.
  - Otherwise the background is used if its req=1; the key is not tested on the background.
  - Otherwise the output is 12'h000.
  - If snapshot `video_on`=0, the output is forced to 12'h000 regardless of layers.
- `rgb_valid` pulses exactly once per accepted window, in the same cycle `rgb_out` changes.
- A `pixel_tick` seen in FETCH before its final slot is ignored and sets `overrun`=1. The in-flight fetch completes unchanged.
- `overrun` is cleared only by reset.
- Reset mid-window: all state returns to reset values, no `rgb_valid` is produced for the aborted window, and pending captures are discarded.

## Timing
- Reset values:
  - `sram_en`=0, `sram_addr`=0
  - `rgb_out`=12'h000, `rgb_valid`=0, `overrun`=0
  - state IDLE, `slot`=0
  - snapshots and captures 0
- With `pixel_tick` at cycle T:
  - slot k is issued at T+1+k;
  - its data is captured at T+2+k;
  - `rgb_out`/`rgb_valid` update at T+N_LAYERS+2, which is T+6 for N=4.
- Minimum `pixel_tick` spacing is N_LAYERS cycles. At exactly that spacing, window n+1's slot 0 capture lands one cycle after window n's compose, so no data hazard exists.
- `rgb_out` holds its value between valid pulses.

## Structure
- Package `layer_fetch_pkg`:
  - state enum {IDLE, FETCH};
  - default `KEY`;
  - `DATA_W`/`ADDR_W` constants;
  - black pixel constant 12'h000.
- Sub-module `layer_priority_mux`: a combinational compose of cap[], snap_req[], snap_video_on and KEY to a pixel. It is instantiated once and has its own unit test.

## Test plan
- Background only: req=4'b1000, addr3=17'd100, SRAM[100]=12'h123, tick at T -> one `sram_en` at T+4, `rgb_out`=12'h123 with `rgb_valid` at T+6, no other `sram_en`.
- Transparency: req=4'b1001, SRAM[addr0]=12'h0f0, SRAM[addr3]=12'habc -> `rgb_out`=12'habc. Changing SRAM[addr0] to 12'hf00 -> `rgb_out`=12'hf00.
- Priority: req=4'b1111, layers 0..3 return 12'h0f0, 12'h00f, 12'hff0, 12'h111 -> `rgb_out`=12'h00f.
- Blanking/back-to-back: ticks every 4 cycles for 8 windows with alternating `video_on` -> 8 `rgb_valid` pulses, odd windows 12'h000, `overrun`=0. Addresses changing every cycle after each tick do not affect results, confirming the snapshot.
- Overrun: tick at T and T+2 -> `overrun`=1 from T+3, exactly one `rgb_valid` (T+6), still set after 100 idle cycles.
- Reset at T+3 of a window -> no `rgb_valid`, all outputs at reset values at T+4, next tick fetches normally.
